pipe_adder: RTL

- Parametrised, pipelined successor to the combinational ripple/CLA adder.
- Splits a WIDTH-bit add/subtract into STAGES segments, one per clock, with the carry registered between segments.
- Valid/ready handshake on both sides with backpressure.
- Used where wide adds (64-256 bit) must close timing at full clock rate in streaming datapaths.

---
 rtl/pipe_adder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined WIDTH-bit add/subtract. The operation is split into STAGES
//   segments of SEG = WIDTH/STAGES bits, one segment per clock, with the carry
//   registered between segments. Operands not yet consumed travel down the
//   pipe alongside the partial result. Completed low segments also travel
//   down the pipe, so the full result appears aligned in the last stage
//   register.
//
//   Parameters
//     WIDTH     operand/result width, multiple of STAGES
//     STAGES    pipeline depth (>= 1), latency in cycles
//     ALGORITHM 0: ripple-carry segments, 1: 4-bit block carry-look-ahead
//               segments (SEG multiple of 4). No effect on function/latency.
//
//   Ports
//     clk, rst             rising-edge clock, synchronous active-high reset
//     in_valid/in_ready    input handshake (in_ready = global enable)
//     in0, in1, cin, sub   operands; sub=1 computes in0 - in1 - cin
//     out_valid/out_ready  output handshake with backpressure
//     sum, cout, ovf       result mod 2^WIDTH, raw top carry, signed overflow
// -----------------------------------------------------------------------------
module pipe_adder #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STAGES    = 4,
  parameter int unsigned ALGORITHM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG     = WIDTH / STAGES;
  localparam bit          USE_CLA = (ALGORITHM == 1) && ((SEG % 4) == 0);

  // Whole pipeline advances together; it only freezes when a finished
  // result is waiting on the downstream side.
  logic             w_en;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;

  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;

  // Subtraction as A + ~B + ~borrow_in.
  assign w_bx = sub ? ~in1 : in1;
  assign w_c0 = sub ? ~cin : cin;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be consumed after this stage.
      localparam int unsigned HI = WIDTH - (k + 1) * SEG;

      logic [SEG-1:0]         w_sa;
      logic [SEG-1:0]         w_sb;
      logic [SEG-1:0]         w_seg;
      logic                   w_ci;
      logic                   w_co;
      logic                   w_vi;
      logic [(k+1)*SEG-1:0]   w_sum_nx;

      logic                   r_v;
      logic                   r_c;
      logic [(k+1)*SEG-1:0]   r_sum;

      // Segment sources: module inputs for the first stage, otherwise the
      // bottom of the operand bits forwarded by the previous stage.
      if (k == 0) begin : g_src
        assign w_sa     = in0[SEG-1:0];
        assign w_sb     = w_bx[SEG-1:0];
        assign w_ci     = w_c0;
        assign w_vi     = in_valid;
        assign w_sum_nx = w_seg;
      end else begin : g_src
        assign w_sa     = g_stage[k-1].g_fwd.r_ahi[SEG-1:0];
        assign w_sb     = g_stage[k-1].g_fwd.r_bhi[SEG-1:0];
        assign w_ci     = g_stage[k-1].r_c;
        assign w_vi     = g_stage[k-1].r_v;
        assign w_sum_nx = {w_seg, g_stage[k-1].r_sum};
      end

      // Segment adder.
      if (USE_CLA) begin : g_cla
        // 4-bit look-ahead groups, group carries rippled between groups.
        always_comb begin
          logic       cc;
          logic [3:0] p;
          logic [3:0] g;
          logic [4:0] c;
          w_seg = '0;
          cc    = w_ci;
          p     = '0;
          g     = '0;
          c     = '0;
          for (int unsigned j = 0; j < SEG / 4; j++) begin
            p    = w_sa[4*j +: 4] ^ w_sb[4*j +: 4];
            g    = w_sa[4*j +: 4] & w_sb[4*j +: 4];
            c[0] = cc;
            c[1] = g[0] | (p[0] & c[0]);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c[0]);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c[0]);
            w_seg[4*j +: 4] = p ^ c[3:0];
            cc = c[4];
          end
          w_co = cc;
        end
      end else begin : g_rca
        always_comb begin
          logic cc;
          w_seg = '0;
          cc    = w_ci;
          for (int unsigned i = 0; i < SEG; i++) begin
            w_seg[i] = w_sa[i] ^ w_sb[i] ^ cc;
            cc       = (w_sa[i] & w_sb[i]) | (cc & (w_sa[i] ^ w_sb[i]));
          end
          w_co = cc;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_v   <= 1'b0;
          r_c   <= 1'b0;
          r_sum <= '0;
        end else if (w_en) begin
          r_v   <= w_vi;
          r_c   <= w_co;
          r_sum <= w_sum_nx;
        end
      end

      // Operand skew: upper segments (including the sign bits) wait here
      // until their carry arrives.
      if (HI > 0) begin : g_fwd
        logic [HI-1:0] w_ahi;
        logic [HI-1:0] w_bhi;
        logic [HI-1:0] r_ahi;
        logic [HI-1:0] r_bhi;

        if (k == 0) begin : g_hsrc
          assign w_ahi = in0[WIDTH-1:SEG];
          assign w_bhi = w_bx[WIDTH-1:SEG];
        end else begin : g_hsrc
          assign w_ahi = g_stage[k-1].g_fwd.r_ahi[HI+SEG-1:SEG];
          assign w_bhi = g_stage[k-1].g_fwd.r_bhi[HI+SEG-1:SEG];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            r_ahi <= '0;
            r_bhi <= '0;
          end else if (w_en) begin
            r_ahi <= w_ahi;
            r_bhi <= w_bhi;
          end
        end
      end

      // The top segment carries the sign bits of A and B', so overflow is
      // resolved alongside the final segment sum.
      if (k == STAGES - 1) begin : g_flag
        logic r_ovf;

        always_ff @(posedge clk) begin
          if (rst) begin
            r_ovf <= 1'b0;
          end else if (w_en) begin
            r_ovf <= (w_sa[SEG-1] == w_sb[SEG-1]) && (w_seg[SEG-1] != w_sa[SEG-1]);
          end
        end
      end
    end
  endgenerate

  assign out_valid = g_stage[STAGES-1].r_v;
  assign sum       = g_stage[STAGES-1].r_sum;
  assign cout      = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_flag.r_ovf;

endmodule
